seq_pack_5x3b_to_4x4b_ctrl: RTL
===============================

// Module: seq_pack_5x3b_to_4x4b_ctrl
// PURPOSE
//  Stream-side controller for the 5x3b->4x4b frame repack. Collects NSYM 3-bit symbols
//  from a val/rdy input stream and forms the 16-bit frame {1'b1, s4,s3,s2,s1,s0}.
//  Emits the frame as NNIB 4-bit nibbles, LSB nibble first, on a val/rdy output stream.
//  Sits between the symbol source and the nibble-wide link serializer.
// PARAMETERS
//  NSYM   5  symbols per frame
//  SYM_W  3  symbol width (bits)
//  NIB_W  4  output nibble width (bits)
//  NNIB   4  nibbles per frame; must satisfy NSYM*SYM_W+1 == NNIB*NIB_W (elaboration check)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_val     in   1      input symbol valid
//  in_rdy     out  1      controller can accept a symbol
//  in_msg     in   SYM_W  input symbol
//  flush      in   1      close the current partial frame, zero-padding the missing symbols
//  out_val    out  1      output nibble valid
//  out_rdy    in   1      downstream accepts nibble
//  out_msg    out  NIB_W  output nibble
//  out_last   out  1      high with the final nibble (idx NNIB-1) of a frame
//  frame_cnt  out  8      count of fully emitted frames; wraps 255->0
// BEHAVIOUR
//  - Reset (async, any state): state=FILL, sym_cnt=0, nib_idx=0, frame buffer=0, frame_cnt=0.
//    Outputs during/after reset: in_rdy=1, out_val=0, out_msg=0, out_last=0, frame_cnt=0.
//    A partial or in-flight frame is discarded; no nibble of it is ever emitted.
//  - FSM states:
//    FILL: in_rdy=1, out_val=0.
//      On in_val: the symbol is written to slot sym_cnt and sym_cnt increments.
//    EMIT: in_rdy=0, out_val=1, out_msg=frame[nib_idx*NIB_W +: NIB_W].
//  - FILL->EMIT occurs when either condition holds:
//    (a) the accepted symbol fills slot NSYM-1;
//    (b) flush=1 and (sym_cnt>0 or a symbol is accepted that cycle).
//    The frame latches that edge; slots not yet written are 0; bit 15 is always 1.
//  - A flush with sym_cnt==0 and no accepted symbol is ignored.
//  - In the flush+in_val cycle, the symbol is accepted into the frame before closing.
//  - Flush in EMIT is ignored.
//  - EMIT: a nibble transfers when out_val & out_rdy, then nib_idx increments.
//    When out_rdy=0, out_msg/out_last hold stable (no drop, no change).
//  - On transfer of nib_idx==NNIB-1 (out_last=1): frame_cnt+=1, sym_cnt=0, nib_idx=0, go to FILL.
//    in_rdy rises the next cycle; no overlap between fill and emit.
//  - Latency: the last symbol is accepted at edge N; nibble 0 is valid in cycle N+1.
//    Minimum frame period is NSYM+NNIB = 9 cycles.
//  - out_msg=0 and out_last=0 whenever out_val=0.
//  - in_rdy and out_val decode only from the state register (no comb path from in_val/out_rdy).
//  - Counters: sym_cnt is $clog2(NSYM+1) bits, nib_idx is $clog2(NNIB) bits.
//    Neither may exceed its terminal value.
// STRUCTURE
//  - Shared package seq_pack_pkg: typedef enum logic {FILL, EMIT} state_t;
//    localparams FRAME_W=16 and MARKER=1'b1; typedefs sym_t=logic[2:0], nib_t=logic[3:0].
//  - One sub-module: frame_pack_5x3b_comb, a purely combinational
//    {MARKER, s4..s0} -> 16-bit concatenation feeding the frame register.
//  - Nibble select is a mux on nib_idx in the top module.
// TESTING
//  1. Reset, then symbols 0,1,2,3,4 with out_rdy=1 -> nibbles 0x8,0x8,0x6,0xC;
//     out_last only on 0xC; frame_cnt=1.
//  2. Five symbols of 7 -> nibbles 0xF,0xF,0xF,0xF; back-to-back second frame;
//     in_rdy=0 throughout EMIT; frame_cnt=2.
//  3. Symbols 7,5 then flush (no in_val) -> nibbles 0xF,0x2,0x0,0x8 (frame 0x802F).
//     Also: flush in same cycle as 3rd symbol 1 -> frame 0x806F.
//  4. Backpressure: out_rdy held 0 for 5 cycles mid-frame -> out_msg/out_last stable,
//     no nibble skipped or repeated, frame_cnt increments once.
//  5. Assert reset asynchronously after 3 symbols, and separately during EMIT
//     nib_idx=2 -> outputs immediately at reset values; next frame 0..4 emits 0x8,0x8,0x6,0xC.
//  6. 256 frames -> frame_cnt wraps to 0.
//     Flush with empty buffer -> no out_val, state stays FILL.

Source files
------------

// File: rtl/seq_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pack_pkg
// Brief    : Shared types and constants for the 5x3b -> 4x4b frame repacker.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pack_pkg;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int   FRAME_W = 16;
    localparam logic MARKER  = 1'b1;
    localparam int   PAY_W   = FRAME_W - 1;

    typedef logic [2:0] sym_t;
    typedef logic [3:0] nib_t;

endpackage : seq_pack_pkg
`default_nettype wire

// File: rtl/frame_pack_5x3b_comb.sv
`default_nettype none
// ============================================================================
// Module   : frame_pack_5x3b_comb
// Brief    : Places the marker bit above the five packed symbols {s4..s0}.
// Revision : 1.0 - initial release
// ============================================================================
module frame_pack_5x3b_comb
    import seq_pack_pkg::*;
(
    input  logic [PAY_W-1:0]   syms,
    output logic [FRAME_W-1:0] frame
);

    assign frame = {MARKER, syms};

endmodule : frame_pack_5x3b_comb
`default_nettype wire

// File: rtl/seq_pack_5x3b_to_4x4b_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_pack_5x3b_to_4x4b_ctrl
// Brief    : Collects 3-bit symbols into a marked 16-bit frame and emits it as
//            four 4-bit nibbles, LSB nibble first, over val/rdy streams.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pack_5x3b_to_4x4b_ctrl
    import seq_pack_pkg::*;
#(
    parameter int NSYM  = 5,
    parameter int SYM_W = 3,
    parameter int NIB_W = 4,
    parameter int NNIB  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [SYM_W-1:0] in_msg,
    input  logic             flush,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NIB_W-1:0] out_msg,
    output logic             out_last,
    output logic [7:0]       frame_cnt
);

    localparam int CNT_W = $clog2(NSYM + 1);
    localparam int IDX_W = $clog2(NNIB);
    localparam int SYMS_W = NSYM * SYM_W;

    generate
        if ((SYMS_W + 1 != NNIB * NIB_W) || (SYMS_W != PAY_W)) begin : g_bad_geometry
            $error("seq_pack_5x3b_to_4x4b_ctrl: NSYM*SYM_W+1 must equal NNIB*NIB_W and FRAME_W");
        end
    endgenerate

    state_t              r_state;
    logic [CNT_W-1:0]    r_sym_cnt;
    logic [IDX_W-1:0]    r_nib_idx;
    logic [SYMS_W-1:0]   r_syms;
    logic [FRAME_W-1:0]  r_frame;
    logic [7:0]          r_frame_cnt;

    logic                w_accept;
    logic                w_fill_done;
    logic                w_flush_close;
    logic                w_close;
    logic                w_last_idx;
    logic [SYMS_W-1:0]   w_syms_next;
    logic [FRAME_W-1:0]  w_frame;
    logic [NIB_W-1:0]    w_nib;

    assign w_accept      = (r_state == FILL) && in_val;
    assign w_fill_done   = w_accept && (r_sym_cnt == CNT_W'(NSYM - 1));
    assign w_flush_close = (r_state == FILL) && flush && ((r_sym_cnt != '0) || w_accept);
    assign w_close       = w_fill_done || w_flush_close;
    assign w_last_idx    = (r_nib_idx == IDX_W'(NNIB - 1));

    // Symbol buffer with this cycle's accepted symbol already merged, so a
    // closing edge (full or flush) latches the frame including that symbol.
    always_comb begin
        w_syms_next = r_syms;
        for (int i = 0; i < NSYM; i++) begin
            if (w_accept && (r_sym_cnt == CNT_W'(i))) begin
                w_syms_next[i*SYM_W +: SYM_W] = in_msg;
            end
        end
    end

    frame_pack_5x3b_comb u_frame_pack (
        .syms  (w_syms_next),
        .frame (w_frame)
    );

    always_comb begin
        w_nib = '0;
        for (int i = 0; i < NNIB; i++) begin
            if (r_nib_idx == IDX_W'(i)) begin
                w_nib = r_frame[i*NIB_W +: NIB_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= FILL;
            r_sym_cnt   <= '0;
            r_nib_idx   <= '0;
            r_syms      <= '0;
            r_frame     <= '0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end
                    if (w_close) begin
                        r_frame <= w_frame;
                        // Clear the buffer so the next partial frame pads with zeros.
                        r_syms  <= '0;
                        r_state <= EMIT;
                    end else begin
                        r_syms  <= w_syms_next;
                    end
                end
                EMIT: begin
                    if (out_rdy) begin
                        if (w_last_idx) begin
                            r_nib_idx   <= '0;
                            r_sym_cnt   <= '0;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            r_state     <= FILL;
                        end else begin
                            r_nib_idx   <= r_nib_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign in_rdy    = (r_state == FILL);
    assign out_val   = (r_state == EMIT);
    assign out_msg   = out_val ? w_nib : '0;
    assign out_last  = out_val && w_last_idx;
    assign frame_cnt = r_frame_cnt;

endmodule : seq_pack_5x3b_to_4x4b_ctrl
`default_nettype wire
